// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave transmit path.
package i2c_slave_pkg;

  localparam int unsigned DEF_CNT_W     = 8;
  localparam int unsigned BIT_CNT_W     = 4;
  localparam logic [7:0]  DEF_FILL_BYTE = 8'hFF;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_ACK       = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/i2c_slave_tx_ctrl_if.sv
// Bus bundle between the TX sequencer, the SCL/SDA front end, address decoder and TX FIFO.
interface i2c_slave_tx_ctrl_if
  import i2c_slave_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic             rd_start;
  logic             sda_in;
  logic             fifo_empty;
  logic             fifo_wr_en;
  logic [7:0]       fifo_data;
  logic             fifo_rd_en;
  logic             sda_oe;
  logic             busy;
  logic             underrun;
  logic             nack_done;
  logic [CNT_W-1:0] byte_cnt;

  // Sequencer side
  modport slave (
    input  scl_rise, scl_fall, start_det, stop_det, rd_start, sda_in,
           fifo_empty, fifo_wr_en, fifo_data,
    output fifo_rd_en, sda_oe, busy, underrun, nack_done, byte_cnt
  );

  // Environment side (front end, decoder, FIFO)
  modport master (
    output scl_rise, scl_fall, start_det, stop_det, rd_start, sda_in,
           fifo_empty, fifo_wr_en, fifo_data,
    input  fifo_rd_en, sda_oe, busy, underrun, nack_done, byte_cnt
  );

endinterface

// File: rtl/i2c_tx_shifter.sv
// 8-bit MSB-first load/shift register with bit counter and registered last-bit flag.
module i2c_tx_shifter
  import i2c_slave_pkg::*;
#(
  parameter logic [7:0] RST_VAL = DEF_FILL_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       start,
  input  logic       shift,
  output logic       msb,
  output logic       next_bit,
  output logic       last_bit
);

  logic [7:0]           sreg;
  logic [BIT_CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg     <= RST_VAL;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (load) begin
      sreg     <= load_data;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (start) begin
      bit_cnt  <= BIT_CNT_W'(1);
      last_bit <= 1'b0;
    end else if (shift) begin
      sreg     <= {sreg[6:0], 1'b1};
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      // The shift that brings the count to 8 marks the last data bit on the wire
      last_bit <= (bit_cnt == BIT_CNT_W'(7));
    end
  end

  assign msb      = sreg[7];
  assign next_bit = sreg[6];

endmodule

// File: rtl/i2c_slave_tx_ctrl.sv
// I2C slave read-path sequencer: pops TX FIFO bytes and serialises them MSB-first on SDA.
module i2c_slave_tx_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [7:0]  FILL_BYTE = DEF_FILL_BYTE,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  i2c_slave_tx_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q;
  logic             underrun_q, underrun_d;
  logic             nack_q, nack_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic             abort;
  logic             pop_c;
  logic             sh_load, sh_start, sh_shift;
  logic [7:0]       sh_data;
  logic             sh_msb, sh_next, sh_last;

  assign abort = bus.start_det | bus.stop_det;

  // Combinational pop so it can never coincide with a FIFO write
  assign pop_c = (state_q == ST_FETCH) && !abort && !bus.fifo_empty && !bus.fifo_wr_en;

  i2c_tx_shifter #(.RST_VAL(FILL_BYTE)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_data),
    .start     (sh_start),
    .shift     (sh_shift),
    .msb       (sh_msb),
    .next_bit  (sh_next),
    .last_bit  (sh_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      nack_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= (state_d != ST_IDLE);
      underrun_q <= underrun_d;
      nack_q     <= nack_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    sda_oe_d   = sda_oe_q;
    underrun_d = 1'b0;
    nack_d     = 1'b0;
    byte_cnt_d = byte_cnt_q;
    sh_load    = 1'b0;
    sh_data    = bus.fifo_data;
    sh_start   = 1'b0;
    sh_shift   = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
          if (bus.rd_start) begin
            state_d    = ST_FETCH;
            byte_cnt_d = '0;
          end
        end
        ST_FETCH: begin
          if (bus.fifo_empty) begin
            sh_load    = 1'b1;
            sh_data    = FILL_BYTE;
            underrun_d = 1'b1;
            state_d    = ST_WAIT_FALL;
          end else if (pop_c) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          sh_load = 1'b1;
          state_d = ST_WAIT_FALL;
        end
        ST_WAIT_FALL: begin
          if (bus.scl_fall) begin
            sh_start = 1'b1;
            sda_oe_d = ~sh_msb;
            state_d  = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.scl_fall) begin
            if (sh_last) begin
              sda_oe_d = 1'b0;
              state_d  = ST_ACK;
            end else begin
              sh_shift = 1'b1;
              sda_oe_d = ~sh_next;
            end
          end
        end
        ST_ACK: begin
          sda_oe_d = 1'b0;
          if (bus.scl_rise) begin
            if (byte_cnt_q != {CNT_W{1'b1}}) begin
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
            if (bus.sda_in == ACK_LVL) begin
              state_d = ST_FETCH;
            end else begin
              nack_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = pop_c;
  assign bus.sda_oe     = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.underrun   = underrun_q;
  assign bus.nack_done  = nack_q;
  assign bus.byte_cnt   = byte_cnt_q;

endmodule
